// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter: 3-way arbiter sharing one sprite memory read port (fire, fireTwo, player)
//   vga_clk    in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   arb_en     in   allows new grants while high; reads in flight always complete
//   req        in   [3] per-requester request, held until ack
//   req_addr   in   [3*ADDR_W] per-requester address, slice i = [i*ADDR_W +: ADDR_W]
//   ack        out  [3] one-cycle grant pulse
//   mem_rd_en  out  read strobe to sprite memory
//   mem_addr   out  [ADDR_W] read address, holds between reads
//   mem_rdata  in   [DATA_W] memory data, valid RD_LAT cycles after mem_rd_en
//   rsp_valid  out  [3] one-hot response strobe, RD_LAT+1 cycles after ack
//   rsp_data   out  [DATA_W] response word, holds between responses
//   busy       out  high while any read is in flight
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2 instead of round-robin.
module sprite_fetch_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 24,
   parameter int RD_LAT = 2
) (
   input  logic                vga_clk,
   input  logic                reset_n,
   input  logic                arb_en,
   input  logic [2:0]          req,
   input  logic [3*ADDR_W-1:0] req_addr,
   output logic [2:0]          ack,
   output logic                mem_rd_en,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [2:0]          rsp_valid,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                busy
);
   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
   state_t            r_state;
   logic [1:0]        r_gid;
   logic [RD_LAT-1:0] r_pv;
   logic [1:0]        r_pid [RD_LAT];
   logic [2:0]        w_elig;
   logic [1:0]        w_win;
   logic              w_gnt;
   // the requester acked this cycle still shows req, so it is masked
   assign w_elig = req & ~ack;
   assign w_gnt  = arb_en & |w_elig;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
   assign w_win = w_elig[0] ? 2'd0 : w_elig[1] ? 2'd1 : 2'd2;
`else
   logic [1:0] r_last, w_s0, w_s1, w_s2;
   assign w_s0  = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
   assign w_s1  = (w_s0 == 2'd2) ? 2'd0 : w_s0 + 2'd1;
   assign w_s2  = (w_s1 == 2'd2) ? 2'd0 : w_s1 + 2'd1;
   assign w_win = w_elig[w_s0] ? w_s0 : w_elig[w_s1] ? w_s1 : w_s2;
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) r_last <= 2'd2;
      else if (w_gnt) r_last <= w_win;
   end
`endif
   // state ACTIVE/DRAIN exactly while a read sits in the issue, pipeline or response stage
   assign busy = (r_state != IDLE);
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         ack       <= '0;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         r_gid     <= '0;
         r_pv      <= '0;
         for (int k = 0; k < RD_LAT; k++) r_pid[k] <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         r_state   <= IDLE;
      end else begin
         ack       <= w_gnt ? 3'b001 << w_win : 3'b000;
         mem_rd_en <= w_gnt;
         if (w_gnt) begin
            mem_addr <= req_addr[w_win*ADDR_W +: ADDR_W];
            r_gid    <= w_win;
         end
         // id travels with the read so the response can be steered when data lands
         r_pv[0]  <= mem_rd_en;
         r_pid[0] <= r_gid;
         for (int k = 1; k < RD_LAT; k++) begin
            r_pv[k]  <= r_pv[k-1];
            r_pid[k] <= r_pid[k-1];
         end
         rsp_valid <= r_pv[RD_LAT-1] ? 3'b001 << r_pid[RD_LAT-1] : 3'b000;
         if (r_pv[RD_LAT-1]) rsp_data <= mem_rdata;
         // next cycle holds a read iff a grant is made now or one is already issued/in the pipe
         r_state <= w_gnt ? ACTIVE : !(mem_rd_en | |r_pv) ? IDLE : arb_en ? ACTIVE : DRAIN;
      end
   end
endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// tb_sprite_fetch_arbiter: table-driven, directed and randomized check of sprite_fetch_arbiter against a transaction model
module tb_sprite_fetch_arbiter;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 24;
   localparam int RD_LAT = 2;
   typedef struct {
      bit         rs;
      logic [2:0] req;
      logic       en;
      logic [2:0] ack;
      logic [2:0] rv;
      logic       busy;
   } vec_t;
   typedef struct {
      int                ack_c;
      int                due;
      int                id;
      logic [DATA_W-1:0] data;
   } rd_t;
   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;
   logic arb_en = 1'b0;
   logic [2:0] req = 3'b000;
   logic [ADDR_W-1:0] a [3];
   logic [3*ADDR_W-1:0] req_addr;
   logic [2:0] ack, rsp_valid;
   logic mem_rd_en, busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [DATA_W-1:0] rsp_data;
   rd_t q[$];
   int cyc, last, n_cmp, n_bad;
   logic [2:0] exp_ack;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_data;
   logic [DATA_W-1:0] mb [8];
   bit mv [8];
   assign req_addr = {a[2], a[1], a[0]};
   always #5 vga_clk = ~vga_clk;
   sprite_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .arb_en(arb_en), .req(req), .req_addr(req_addr),
      .ack(ack), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
   );
   function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] x);
      return (x == 12'h123) ? 24'hFE9533 : {x[3:0], x, ~x[7:0]};
   endfunction
   function automatic vec_t mk(input bit rs, input logic [2:0] r, input logic en,
                               input logic [2:0] ak, input logic [2:0] rv, input logic b);
      vec_t v;
      v = '{rs, r, en, ak, rv, b};
      return v;
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   // compare this cycle's outputs with what the transaction list says is due now
   task automatic model_check();
      logic [2:0] erv;
      logic eb;
      erv = 3'b000;
      eb = 1'b0;
      foreach (q[j]) begin
         if (q[j].due == cyc) begin
            erv = 3'b001 << q[j].id;
            exp_data = q[j].data;
         end
         if (q[j].ack_c <= cyc && cyc <= q[j].due) eb = 1'b1;
      end
      chk("ack", 64'(ack), 64'(exp_ack));
      chk("mem_rd_en", 64'(mem_rd_en), 64'(|exp_ack));
      chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
      chk("rsp_valid", 64'(rsp_valid), 64'(erv));
      chk("rsp_data", 64'(rsp_data), 64'(exp_data));
      chk("busy", 64'(busy), 64'(eb));
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
   endtask
   // memory: answers each strobe RD_LAT cycles later, junk otherwise
   task automatic mem_step();
      if (mem_rd_en) begin
         mb[(cyc + RD_LAT) % 8] = memf(mem_addr);
         mv[(cyc + RD_LAT) % 8] = 1'b1;
      end
      mem_rdata = mv[cyc % 8] ? mb[cyc % 8] : DATA_W'($urandom);
      mv[cyc % 8] = 1'b0;
   endtask
   // decide the grant for next cycle from the inputs just driven
   task automatic predict();
      logic [2:0] el;
      rd_t t;
      int w;
      el = req & ~exp_ack;
      exp_ack = 3'b000;
      w = -1;
      if (arb_en && el != 3'b000) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
         for (int k = 0; k < 3; k++) if (w < 0 && el[k]) w = k;
`else
         for (int k = 1; k <= 3; k++) if (w < 0 && el[(last + k) % 3]) w = (last + k) % 3;
`endif
         exp_ack[w] = 1'b1;
         exp_addr = a[w];
         last = w;
         t = '{cyc + 1, cyc + 2 + RD_LAT, w, memf(a[w])};
         q.push_back(t);
      end
      cyc++;
   endtask
   task automatic step(input logic [2:0] r, input logic en, input bit rnd);
      @(negedge vga_clk);
      model_check();
      mem_step();
      if (rnd) begin
         for (int i = 0; i < 3; i++)
            if (req[i] ? ack[i] : ($urandom_range(4) < 2)) begin
               req[i] = !req[i] || ($urandom_range(1) == 1);
               a[i] = ADDR_W'($urandom);
            end
         arb_en = ($urandom_range(7) != 0);
      end else begin
         req = r;
         arb_en = en;
      end
      predict();
   endtask
   task automatic do_reset(input logic [2:0] r, input logic en);
      @(negedge vga_clk);
      reset_n = 1'b0;
      q.delete();
      foreach (mv[j]) mv[j] = 1'b0;
      exp_ack = 3'b000;
      exp_addr = '0;
      exp_data = '0;
      last = 2;
      @(negedge vga_clk);
      chk("reset_outputs", 64'({ack, mem_rd_en, mem_addr, rsp_valid, rsp_data, busy}), 64'(0));
      reset_n = 1'b1;
      req = r;
      arb_en = en;
      cyc = 0;
      predict();
   endtask
   initial begin
      vec_t tab[$];
      logic [2:0] ord [6];
      n_cmp = 0;
      n_bad = 0;
      cyc = 0;
      last = 2;
      a[0] = 12'h123;
      a[1] = 12'h456;
      a[2] = 12'h789;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      ord = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`else
      ord = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
      // single request, response three cycles after ack
      tab.push_back(mk(1, 3'b001, 1, 3'b000, 3'b000, 0));
      tab.push_back(mk(0, 3'b000, 1, 3'b001, 3'b000, 1));
      tab.push_back(mk(0, 3'b000, 1, 3'b000, 3'b000, 1));
      tab.push_back(mk(0, 3'b000, 1, 3'b000, 3'b000, 1));
      tab.push_back(mk(0, 3'b000, 1, 3'b000, 3'b001, 1));
      tab.push_back(mk(0, 3'b000, 1, 3'b000, 3'b000, 0));
      // all three requesting continuously
      for (int i = 0; i <= 10; i++)
         tab.push_back(mk(i == 0, (i <= 5) ? 3'b111 : 3'b000, 1,
                          (i >= 1 && i <= 6) ? ord[(i + 5) % 6] : 3'b000,
                          (i >= 4 && i <= 9) ? ord[(i + 2) % 6] : 3'b000,
                          i >= 1 && i <= 9));
      // arb_en drops after two grants; both reads still complete
      tab.push_back(mk(1, 3'b011, 1, 3'b000, 3'b000, 0));
      tab.push_back(mk(0, 3'b011, 1, 3'b001, 3'b000, 1));
      tab.push_back(mk(0, 3'b011, 0, 3'b010, 3'b000, 1));
      tab.push_back(mk(0, 3'b011, 0, 3'b000, 3'b000, 1));
      tab.push_back(mk(0, 3'b011, 0, 3'b000, 3'b001, 1));
      tab.push_back(mk(0, 3'b011, 0, 3'b000, 3'b010, 1));
      tab.push_back(mk(0, 3'b011, 0, 3'b000, 3'b000, 0));
      tab.push_back(mk(0, 3'b011, 0, 3'b000, 3'b000, 0));
      foreach (tab[t]) begin
         if (tab[t].rs) do_reset(3'b000, 1'b0);
         step(tab[t].req, tab[t].en, 1'b0);
         chk("tab_ack", 64'(ack), 64'(tab[t].ack));
         chk("tab_rsp_valid", 64'(rsp_valid), 64'(tab[t].rv));
         chk("tab_busy", 64'(busy), 64'(tab[t].busy));
      end
      // back-to-back: a read strobe on six consecutive cycles
      do_reset(3'b011, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         step((k < 6) ? 3'b011 : 3'b000, 1'b1, 1'b0);
         chk("b2b_rd_en", 64'(mem_rd_en), 64'(1));
      end
      for (int k = 0; k < 5; k++) step(3'b000, 1'b1, 1'b0);
      // reset one cycle after an ack flushes the read
      do_reset(3'b000, 1'b0);
      step(3'b001, 1'b1, 1'b0);
      step(3'b000, 1'b1, 1'b0);
      chk("mid_ack", 64'(ack), 64'(3'b001));
      do_reset(3'b111, 1'b1);
      step(3'b000, 1'b1, 1'b0);
      chk("post_rst_gnt", 64'(ack), 64'(3'b001));
      chk("post_rst_rv", 64'(rsp_valid), 64'(3'b000));
      for (int k = 0; k < 6; k++) begin
         step(3'b000, 1'b1, 1'b0);
         chk("no_stale_rsp", 64'(rsp_valid), 64'((k == 2) ? 3'b001 : 3'b000));
      end
      // randomized requesters with occasional resets
      for (int k = 0; k < 3000; k++)
         if ($urandom_range(299) == 0) do_reset(3'b000, 1'b0);
         else step(3'b000, 1'b0, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
